// File: rtl/isp_yuv444to422_if.sv
// Pixel bus between the RGB2YUV converter, the 4:4:4 -> 4:2:2 stage and the
// YUV422 packer. The master is whoever drives the 4:4:4 side (the upstream
// converter or a bench). The slave is the 4:2:2 stage.
interface isp_yuv444to422_if #(
    parameter int unsigned BITS = 8
) ();
    // 4:4:4 input side
    logic            in_href;
    logic            in_vsync;
    logic [BITS-1:0] in_y;
    logic [BITS-1:0] in_u;
    logic [BITS-1:0] in_v;

    // 4:2:2 output side
    logic            out_href;
    logic            out_vsync;
    logic [BITS-1:0] out_y;
    logic [BITS-1:0] out_c;
    logic            odd_line_err;

    modport master (
        output in_href, in_vsync, in_y, in_u, in_v,
        input  out_href, out_vsync, out_y, out_c, odd_line_err
    );

    modport slave (
        input  in_href, in_vsync, in_y, in_u, in_v,
        output out_href, out_vsync, out_y, out_c, odd_line_err
    );
endinterface

// File: rtl/isp_yuv444to422.sv
// 4:4:4 -> 4:2:2 chroma subsampler with a fixed 2-pclk latency.
// Y passes through. Chroma is time-multiplexed on out_c: U on even pixels and
// V on odd pixels. Each pair's chroma is either the rounded mean of the pair
// or the even-pixel sample. A line that ends on an even pixel raises a sticky
// odd_line_err flag. The flag clears on the next vsync rise.
module isp_yuv444to422 #(
    parameter int unsigned BITS       = 8,
    parameter int unsigned WIDTH      = 1280,
    parameter int unsigned HEIGHT     = 960,
    parameter bit          CHROMA_AVG = 1'b1
) (
    input logic              pclk,
    input logic              rst,
    isp_yuv444to422_if.slave bus
);

    localparam int unsigned SumW = BITS + 1;

    // Geometry is informational only. This check rejects nonsensical values.
    if (WIDTH < 2 || HEIGHT < 1) begin : g_bad_geometry
        $error("isp_yuv444to422: WIDTH must be >= 2 and HEIGHT >= 1");
    end

    // Input phase: 0 for the even pixel of a pair, 1 for the odd pixel.
    logic            phase_q, phase_d;

    // Stage 1: registered input pixel.
    logic            s1_href_q, s1_href_d;
    logic            s1_vsync_q, s1_vsync_d;
    logic            s1_phase_q, s1_phase_d;
    logic [BITS-1:0] s1_y_q, s1_y_d;
    logic [BITS-1:0] s1_u_q, s1_u_d;
    logic [BITS-1:0] s1_v_q, s1_v_d;

    // Stage 2: output pixel.
    logic            s2_href_q, s2_href_d;
    logic            s2_vsync_q, s2_vsync_d;
    logic            s2_phase_q, s2_phase_d;
    logic [BITS-1:0] s2_y_q, s2_y_d;

    // Chroma hold registers for the pair currently in stage 2.
    logic [BITS-1:0] cu_q, cu_d;
    logic [BITS-1:0] cv_q, cv_d;

    logic            err_q, err_d;

    logic [SumW-1:0] sum_u, sum_v;
    logic            pair_done, lone_p0, vsync_rise;

    // Next-state logic: phase tracking, pair chroma, sticky error.
    always_comb begin
        phase_d    = bus.in_href ? ~phase_q : 1'b0;

        s1_href_d  = bus.in_href;
        s1_vsync_d = bus.in_vsync;
        s1_phase_d = phase_q;
        s1_y_d     = bus.in_y;
        s1_u_d     = bus.in_u;
        s1_v_d     = bus.in_v;

        s2_href_d  = s1_href_q;
        s2_vsync_d = s1_vsync_q;
        s2_phase_d = s1_phase_q;
        s2_y_d     = s1_y_q;

        // One extra bit holds the largest sum 2*(2^BITS-1)+1, so the shifted
        // result always fits in BITS.
        sum_u = {1'b0, s1_u_q} + {1'b0, bus.in_u} + SumW'(1);
        sum_v = {1'b0, s1_v_q} + {1'b0, bus.in_v} + SumW'(1);

        // Stage 1 holds p0 and its p1 is presented now.
        pair_done = bus.in_href & phase_q & s1_href_q & ~s1_phase_q;
        // Stage 1 holds p0 and the line ended before p1 arrived.
        lone_p0   = s1_href_q & ~s1_phase_q & ~bus.in_href;

        cu_d = cu_q;
        cv_d = cv_q;
        if (pair_done) begin
            if (CHROMA_AVG) begin
                cu_d = sum_u[SumW-1:1];
                cv_d = sum_v[SumW-1:1];
            end else begin
                cu_d = s1_u_q;
                cv_d = s1_v_q;
            end
        end else if (lone_p0) begin
            cu_d = s1_u_q;
        end

        vsync_rise = s1_vsync_q & ~s2_vsync_q;

        // A set in the same cycle as a clear wins.
        if (lone_p0) begin
            err_d = 1'b1;
        end else if (vsync_rise) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge pclk) begin
        if (rst) begin
            phase_q    <= 1'b0;
            s1_href_q  <= 1'b0;
            s1_vsync_q <= 1'b0;
            s1_phase_q <= 1'b0;
            s1_y_q     <= '0;
            s1_u_q     <= '0;
            s1_v_q     <= '0;
            s2_href_q  <= 1'b0;
            s2_vsync_q <= 1'b0;
            s2_phase_q <= 1'b0;
            s2_y_q     <= '0;
            cu_q       <= '0;
            cv_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            s1_href_q  <= s1_href_d;
            s1_vsync_q <= s1_vsync_d;
            s1_phase_q <= s1_phase_d;
            s1_y_q     <= s1_y_d;
            s1_u_q     <= s1_u_d;
            s1_v_q     <= s1_v_d;
            s2_href_q  <= s2_href_d;
            s2_vsync_q <= s2_vsync_d;
            s2_phase_q <= s2_phase_d;
            s2_y_q     <= s2_y_d;
            cu_q       <= cu_d;
            cv_q       <= cv_d;
            err_q      <= err_d;
        end
    end

    // Output muxing. Data is forced to zero during blanking.
    always_comb begin
        bus.out_href     = s2_href_q;
        bus.out_vsync    = s2_vsync_q;
        bus.out_y        = s2_href_q ? s2_y_q : '0;
        bus.out_c        = s2_href_q ? (s2_phase_q ? cv_q : cu_q) : '0;
        bus.odd_line_err = err_q;
    end

endmodule

// File: tb/tb_isp_yuv444to422.sv
// Bench for isp_yuv444to422. Three instances share one stimulus stream:
// 8-bit averaging, 8-bit decimating and 10-bit averaging. A line-level model
// works from the recorded input history and predicts every output each cycle.
// Literal expectations for the directed lines pin that model.
module tb_isp_yuv444to422;

    localparam int NMAX = 512;

    logic pclk = 1'b0;
    logic rst;

    always #5 pclk = ~pclk;

    isp_yuv444to422_if #(.BITS(8))  bus_a ();
    isp_yuv444to422_if #(.BITS(8))  bus_d ();
    isp_yuv444to422_if #(.BITS(10)) bus_w ();

    isp_yuv444to422 #(.BITS(8), .CHROMA_AVG(1'b1)) u_dut_a (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus_a)
    );

    isp_yuv444to422 #(.BITS(8), .CHROMA_AVG(1'b0)) u_dut_d (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus_d)
    );

    isp_yuv444to422 #(.BITS(10), .CHROMA_AVG(1'b1)) u_dut_w (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus_w)
    );

    int tests = 0;
    int fails = 0;

    // Values currently driven, kept for the model.
    bit drv_href, drv_vs;
    int drv_y, drv_u, drv_v;

    // Input history, one entry per clock edge. Reset edges record blanking.
    bit r_rst  [NMAX];
    bit r_href [NMAX];
    bit r_vs   [NMAX];
    int r_y    [NMAX];
    int r_u    [NMAX];
    int r_v    [NMAX];
    int n = 0;
    bit err_m = 1'b0;

    int qa[$], qd[$], qw[$], qy[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_seq(input string name, input int act[$], input int exp[$]);
        chk({name, "_len"}, act.size(), exp.size());
        if (act.size() == exp.size()) begin
            foreach (exp[i]) chk($sformatf("%s[%0d]", name, i), act[i], exp[i]);
        end
    endtask

    // Length of the href-high run ending at history index i (1 = first pixel).
    function automatic int run_len(input int i);
        int k = 0;
        int j = i;
        while (j >= 0 && r_href[j]) begin
            k++;
            j--;
        end
        return k;
    endfunction

    // Chroma carried by the pixel at history index i.
    function automatic int exp_c(input int i, input int msk, input bit avg);
        if (run_len(i) % 2 == 1) begin
            if (r_href[i+1]) begin
                return avg ? (((r_u[i] & msk) + (r_u[i+1] & msk) + 1) >> 1) : (r_u[i] & msk);
            end
            return r_u[i] & msk;
        end
        return avg ? (((r_v[i-1] & msk) + (r_v[i] & msk) + 1) >> 1) : (r_v[i-1] & msk);
    endfunction

    task automatic check_out(input string tag, input int msk, input bit avg,
                             input int oh, input int ov, input int oy, input int oc,
                             input int oe);
        bit eh, ev;
        int ey, ec;
        eh = 1'b0;
        ev = 1'b0;
        ey = 0;
        ec = 0;
        if (n >= 2) begin
            eh = r_href[n-2] && !r_rst[n-1];
            ev = r_vs[n-2] && !r_rst[n-1];
            if (eh) begin
                ey = r_y[n-2] & msk;
                ec = exp_c(n - 2, msk, avg);
            end
        end
        chk({tag, "_href"}, oh, int'(eh));
        chk({tag, "_vsync"}, ov, int'(ev));
        chk({tag, "_y"}, oy, ey);
        chk({tag, "_c"}, oc, ec);
        chk({tag, "_err"}, oe, int'(err_m));
    endtask

    // Record the inputs seen at each edge and advance the error-flag model.
    always @(posedge pclk) begin
        bit set_e, clr_e;
        if (n < NMAX) begin
            r_rst[n]  = rst;
            r_href[n] = !rst && drv_href;
            r_vs[n]   = !rst && drv_vs;
            r_y[n]    = drv_y;
            r_u[n]    = drv_u;
            r_v[n]    = drv_v;
            set_e = 1'b0;
            clr_e = 1'b0;
            if (n >= 1) begin
                set_e = r_href[n-1] && (run_len(n - 1) % 2 == 1) && !drv_href;
                clr_e = r_vs[n-1];
                if (n >= 2 && r_vs[n-2] && !r_rst[n-1]) clr_e = 1'b0;
            end
            if (rst) err_m = 1'b0;
            else if (set_e) err_m = 1'b1;
            else if (clr_e) err_m = 1'b0;
            n++;
        end
    end

    // Compare every output of every instance on each falling edge.
    always @(negedge pclk) begin
        if (n >= 1 && n < NMAX) begin
            check_out("a", 255, 1'b1, int'(bus_a.out_href), int'(bus_a.out_vsync),
                      int'(bus_a.out_y), int'(bus_a.out_c), int'(bus_a.odd_line_err));
            check_out("d", 255, 1'b0, int'(bus_d.out_href), int'(bus_d.out_vsync),
                      int'(bus_d.out_y), int'(bus_d.out_c), int'(bus_d.odd_line_err));
            check_out("w", 1023, 1'b1, int'(bus_w.out_href), int'(bus_w.out_vsync),
                      int'(bus_w.out_y), int'(bus_w.out_c), int'(bus_w.odd_line_err));
            if (bus_a.out_href) begin
                qa.push_back(int'(bus_a.out_c));
                qy.push_back(int'(bus_a.out_y));
            end
            if (bus_d.out_href) qd.push_back(int'(bus_d.out_c));
            if (bus_w.out_href) qw.push_back(int'(bus_w.out_c));
        end
    end

    task automatic set_in(input bit r, input bit h, input bit vs, input int y, input int u,
                          input int v);
        rst      = r;
        drv_href = h;
        drv_vs   = vs;
        drv_y    = y;
        drv_u    = u;
        drv_v    = v;
        bus_a.in_href = h;  bus_a.in_vsync = vs;
        bus_a.in_y = 8'(y); bus_a.in_u = 8'(u); bus_a.in_v = 8'(v);
        bus_d.in_href = h;  bus_d.in_vsync = vs;
        bus_d.in_y = 8'(y); bus_d.in_u = 8'(u); bus_d.in_v = 8'(v);
        bus_w.in_href = h;  bus_w.in_vsync = vs;
        bus_w.in_y = 10'(y); bus_w.in_u = 10'(u); bus_w.in_v = 10'(v);
    endtask

    task automatic cyc(input bit r, input bit h, input bit vs, input int y, input int u,
                       input int v);
        @(posedge pclk);
        #1;
        set_in(r, h, vs, y, u, v);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic chk_zero(input string name);
        @(negedge pclk);
        chk({name, "_href"}, int'(bus_a.out_href), 0);
        chk({name, "_y"}, int'(bus_a.out_y), 0);
        chk({name, "_c"}, int'(bus_a.out_c), 0);
    endtask

    task automatic clear_q();
        qa.delete();
        qd.delete();
        qw.delete();
        qy.delete();
    endtask

    int exp_q[$];

    initial begin
        set_in(1'b1, 1'b0, 1'b0, 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0);
        idle(2);

        // Reset in the middle of a line. href stays high throughout.
        cyc(1'b0, 1'b1, 1'b0, 1, 10, 20);
        cyc(1'b0, 1'b1, 1'b0, 2, 30, 40);
        cyc(1'b1, 1'b1, 1'b0, 3, 50, 60);
        cyc(1'b1, 1'b1, 1'b0, 3, 50, 60);
        chk_zero("t1_rst1");
        cyc(1'b1, 1'b1, 1'b0, 3, 50, 60);
        chk_zero("t1_rst2");
        cyc(1'b0, 1'b1, 1'b0, 5, 100, 50);
        chk_zero("t1_rst3");
        cyc(1'b0, 1'b1, 1'b0, 6, 102, 54);
        chk_zero("t1_post1");
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 0);
        @(negedge pclk);
        chk("t1_first_href", int'(bus_a.out_href), 1);
        chk("t1_first_y", int'(bus_a.out_y), 5);
        chk("t1_first_c_avg", int'(bus_a.out_c), 101);
        chk("t1_first_c_dec", int'(bus_d.out_c), 100);
        idle(3);

        // Four-pixel line in both chroma modes.
        clear_q();
        cyc(1'b0, 1'b1, 1'b0, 10, 100, 50);
        cyc(1'b0, 1'b1, 1'b0, 20, 101, 52);
        cyc(1'b0, 1'b1, 1'b0, 30, 200, 7);
        cyc(1'b0, 1'b1, 1'b0, 40, 200, 8);
        idle(4);
        exp_q = '{101, 51, 200, 8};
        chk_seq("t2_c_avg", qa, exp_q);
        chk_seq("t2_c_avg10", qw, exp_q);
        exp_q = '{100, 50, 200, 7};
        chk_seq("t3_c_dec", qd, exp_q);
        exp_q = '{10, 20, 30, 40};
        chk_seq("t2_y", qy, exp_q);

        // Odd-length line sets the sticky flag until the next vsync rise.
        clear_q();
        cyc(1'b0, 1'b1, 1'b0, 1, 60, 30);
        cyc(1'b0, 1'b1, 1'b0, 2, 62, 32);
        cyc(1'b0, 1'b1, 1'b0, 3, 90, 99);
        idle(4);
        exp_q = '{61, 31, 90};
        chk_seq("t4_c", qa, exp_q);
        @(negedge pclk);
        chk("t4_err_set", int'(bus_a.odd_line_err), 1);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 0);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 0);
        idle(3);
        @(negedge pclk);
        chk("t4_err_clr", int'(bus_a.odd_line_err), 0);

        // Limits and back-to-back lines with a vsync pulse in the gap.
        clear_q();
        cyc(1'b0, 1'b1, 1'b0, 1, 255, 0);
        cyc(1'b0, 1'b1, 1'b0, 2, 255, 1);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 0);
        cyc(1'b0, 1'b1, 1'b0, 3, 1023, 1022);
        cyc(1'b0, 1'b1, 1'b0, 4, 1022, 1023);
        idle(4);
        exp_q = '{255, 1, 255, 255};
        chk_seq("t5_c_avg8", qa, exp_q);
        exp_q = '{255, 0, 255, 254};
        chk_seq("t6_c_dec8", qd, exp_q);
        exp_q = '{255, 1, 1023, 1023};
        chk_seq("t5_c_avg10", qw, exp_q);
        @(negedge pclk);
        chk("t6_err_clear", int'(bus_a.odd_line_err), 0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
